// File: rtl/sample_uart_tx.sv
// sample_uart_tx: takes signed samples from a level-valid stream every
// CAP_DIV clocks, buffers them in a 16-byte FIFO and sends each byte on a
// UART 8N1 line at BAUD_DIV clocks per bit.
module sample_uart_tx #(
    parameter logic [15:0] CAP_DIV    = 16'd8192,
    parameter logic [15:0] BAUD_DIV   = 16'd434,
    parameter logic        OFFSET_BIN = 1'b1
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       data_v,
    output logic       tx,
    output logic       busy,
    output logic [4:0] fifo_cnt,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [4:0] FIFO_DEPTH = 5'd16;

    // ------------------------------------------------------------------
    // Sample capture
    // ------------------------------------------------------------------
    logic [15:0] cap_cnt;
    logic        cap_stb;
    logic [7:0]  cap_byte;

    assign cap_stb  = data_v && (cap_cnt == CAP_DIV - 16'd1);
    // Flipping the sign bit turns two's complement into offset binary.
    assign cap_byte = {data_i[7] ^ OFFSET_BIN, data_i[6:0]};

    // Capture counter: counts clocks while data_v is high, restarts whenever it drops.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge sclk) begin
        if (rst) begin
            cap_cnt <= '0;
        end else if (!data_v || cap_stb) begin
            cap_cnt <= '0;
        end else begin
            cap_cnt <= cap_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0] mem [16];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic       full;
    logic       push;
    logic       pop;

    assign full = (fifo_cnt == FIFO_DEPTH);
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push = cap_stb && (!full || pop);

    // FIFO storage write port.
    // NOTE: the storage array is not reset; only pointers and count are, which
    // keeps it mappable to RAM and stale contents are never read.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem[wr_ptr] <= cap_byte;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 4'd1;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (cap_stb && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    state_t      state,    state_n;
    logic [15:0] baud_cnt, baud_n;
    logic [2:0]  bit_cnt,  bit_n;
    logic [7:0]  shreg,    shreg_n;
    logic        tx_n;
    logic        baud_end;

    assign baud_end = (baud_cnt == BAUD_DIV - 16'd1);

    // Transmitter next-state, next-output and FIFO pop decode.
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        tx_n    = tx;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (fifo_cnt != 5'd0) begin
                    pop     = 1'b1;
                    shreg_n = mem[rd_ptr];
                    state_n = START;
                    tx_n    = 1'b0;
                    baud_n  = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_n = DATA;
                    baud_n  = '0;
                    tx_n    = shreg[0];
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shreg_n = shreg >> 1;
                        tx_n    = shreg[1];
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_n = IDLE;
                    baud_n  = '0;
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    // Transmitter state register; tx and busy are registered so they are glitch-free.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_sample_uart_tx.sv
// tb_sample_uart_tx: drives random samples into two sample_uart_tx instances
// (offset binary on and off) and compares every cycle against a frame-level
// model of captures, FIFO occupancy and line waveform.
module tb_sample_uart_tx;

    localparam int CAP  = 16;
    localparam int BAUD = 4;

    logic       sclk;
    logic       rst;
    logic [7:0] data_i;
    logic       data_v;
    logic       tx, busy, ovf;
    logic [4:0] fifo_cnt;
    logic       tx0, busy0, ovf0;
    logic [4:0] fifo_cnt0;

    int checks   = 0;
    int failures = 0;

    sample_uart_tx #(.CAP_DIV(16'd16), .BAUD_DIV(16'd4), .OFFSET_BIN(1'b1)) dut (
        .sclk(sclk), .rst(rst), .data_i(data_i), .data_v(data_v),
        .tx(tx), .busy(busy), .fifo_cnt(fifo_cnt), .ovf(ovf)
    );

    sample_uart_tx #(.CAP_DIV(16'd16), .BAUD_DIV(16'd4), .OFFSET_BIN(1'b0)) dut0 (
        .sclk(sclk), .rst(rst), .data_i(data_i), .data_v(data_v),
        .tx(tx0), .busy(busy0), .fifo_cnt(fifo_cnt0), .ovf(ovf0)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // Reference model: edge counter, queue of buffered bytes, start edge of the
    // frame on the line and the earliest edge the next frame may start.
    int         m_cyc     = 0;
    logic [7:0] m_q[$];
    int         m_fs      = -1000;
    int         m_free_at = 0;
    int         m_run     = 0;
    logic       m_ovf     = 1'b0;
    logic [9:0] m_fbits   = '1;
    logic [9:0] m_fbits0  = '1;

    logic [15:0] obs;
    assign obs = {tx, busy, fifo_cnt, ovf, tx0, busy0, fifo_cnt0, ovf0};

    // Wait for the falling edge, then advance the model over the rising edge just
    // passed, using the inputs that were stable across it.
    task automatic tick();
        logic       can_pop;
        logic       cap;
        logic [7:0] b;
        @(negedge sclk);
        m_cyc++;
        if (rst) begin
            m_q.delete();
            m_ovf     = 1'b0;
            m_run     = 0;
            m_fs      = -1000;
            m_free_at = 0;
        end else begin
            can_pop = (m_cyc >= m_free_at) && (m_q.size() != 0);
            cap     = data_v && (((m_run + 1) % CAP) == 0);
            m_run   = data_v ? m_run + 1 : 0;
            if (can_pop) begin
                b         = m_q.pop_front();
                m_fs      = m_cyc;
                m_fbits   = {1'b1, b, 1'b0};
                m_fbits0  = {1'b1, b ^ 8'h80, 1'b0};
                m_free_at = m_cyc + 10 * BAUD + 1;
            end
            if (cap) begin
                if (m_q.size() < 16) m_q.push_back(data_i ^ 8'h80);
                else                 m_ovf = 1'b1;
            end
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic       on;
        int         slot;
        logic       t, t0;
        logic [4:0] cnt;
        on   = (m_cyc >= m_fs) && (m_cyc < m_fs + 10 * BAUD);
        slot = on ? (m_cyc - m_fs) / BAUD : 0;
        t    = on ? m_fbits[slot]  : 1'b1;
        t0   = on ? m_fbits0[slot] : 1'b1;
        cnt  = 5'(m_q.size());
        return {t, on, cnt, m_ovf, t0, on, cnt, m_ovf};
    endfunction

    task automatic apply_reset();
        rst    = 1'b1;
        data_v = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        data_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = 8'($urandom);
            tick();
        end
        checks++;
        if ({tx, busy, fifo_cnt, ovf} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_out: got tx/busy/cnt/ovf=%b/%b/%0d/%b want 1/0/0/0", tx, busy, fifo_cnt, ovf);
        end
        checks++;
        if ({tx0, busy0, fifo_cnt0, ovf0} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_out0: got tx/busy/cnt/ovf=%b/%b/%0d/%b want 1/0/0/0", tx0, busy0, fifo_cnt0, ovf0);
        end
    endtask

    // One sample held from reset release: capture at edge 16, tx falls at edge 17,
    // bits decoded mid-bit. 0x05 goes out as 0x85 with the sign bit flipped.
    task automatic test_single_frame(input logic [7:0] d, input logic [7:0] want,
                                     input logic [7:0] want0, input string name);
        logic [60:0] log_t, log_t0;
        int          fe, fe0;
        logic [7:0]  rx, rx0;
        log_t  = '1;
        log_t0 = '1;
        apply_reset();
        rst    = 1'b0;
        data_v = 1'b1;
        data_i = d;
        for (int i = 1; i <= 60; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL %s_cycle: edge %0d got %h want %h", name, i, obs, exp_vec());
            end
            log_t[i]  = tx;
            log_t0[i] = tx0;
            if (i == 20) data_v = 1'b0;
        end
        fe  = -1;
        fe0 = -1;
        for (int i = 60; i >= 1; i--) begin
            if (!log_t[i])  fe  = i;
            if (!log_t0[i]) fe0 = i;
        end
        checks++;
        if (fe !== 17) begin
            failures++;
            $display("FAIL %s_fall: tx fell at edge %0d want 17", name, fe);
        end
        checks++;
        if (fe0 !== 17) begin
            failures++;
            $display("FAIL %s_fall0: tx fell at edge %0d want 17", name, fe0);
        end
        for (int j = 0; j < 8; j++) begin
            rx[j]  = log_t[17 + 4 * (j + 1) + 1];
            rx0[j] = log_t0[17 + 4 * (j + 1) + 1];
        end
        checks++;
        if (rx !== want) begin
            failures++;
            $display("FAIL %s_byte: got %h want %h", name, rx, want);
        end
        checks++;
        if (rx0 !== want0) begin
            failures++;
            $display("FAIL %s_byte0: got %h want %h", name, rx0, want0);
        end
        checks++;
        if ({log_t[18], log_t[54]} !== 2'b01) begin
            failures++;
            $display("FAIL %s_framing: start/stop got %b%b want 01", name, log_t[18], log_t[54]);
        end
    endtask

    // data_v low for one clock when the capture count has reached 10.
    task automatic test_vpulse();
        logic [70:0] log_t;
        int          fe;
        log_t = '1;
        apply_reset();
        rst    = 1'b0;
        data_v = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            data_i = (i == 1) ? 8'($urandom) : data_i;
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL vpulse_cycle: edge %0d got %h want %h", i, obs, exp_vec());
            end
            log_t[i] = tx;
            data_i   = 8'($urandom);
            if (i == 10) data_v = 1'b0;
            if (i == 11) data_v = 1'b1;
        end
        fe = -1;
        for (int i = 70; i >= 1; i--) begin
            if (!log_t[i]) fe = i;
        end
        checks++;
        if (fe !== 28) begin
            failures++;
            $display("FAIL vpulse_fall: tx fell at edge %0d want 28", fe);
        end
    endtask

    // Fill to 16, then arrange a capture on the exact edge the transmitter pops.
    task automatic test_full_pop();
        int phase = 0;
        int p     = 0;
        int p2    = 0;
        apply_reset();
        rst    = 1'b0;
        data_v = 1'b1;
        for (int n = 0; n < 3000 && phase < 4; n++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL fullpop_cycle: edge %0d got %h want %h", m_cyc, obs, exp_vec());
            end
            data_i = 8'($urandom);
            case (phase)
                0: if (m_q.size() == 16) begin data_v = 1'b0; p = m_fs; phase = 1; end
                1: if (m_fs != p) begin p2 = m_free_at; phase = 2; end
                2: if (m_cyc == p2 - 32) begin data_v = 1'b1; phase = 3; end
                3: if (m_cyc == p2) begin data_v = 1'b0; phase = 4; end
                default: ;
            endcase
        end
        checks++;
        if (phase !== 4) begin
            failures++;
            $display("FAIL fullpop_timeout: reached phase %0d want 4", phase);
        end
        checks++;
        if ({fifo_cnt, ovf, fifo_cnt0, ovf0} !== {5'd16, 1'b0, 5'd16, 1'b0}) begin
            failures++;
            $display("FAIL fullpop_state: got cnt/ovf=%0d/%b want 16/0", fifo_cnt, ovf);
        end
    endtask

    // Continuous capture outpaces the line: occupancy tops out at 16 and ovf latches.
    task automatic test_overflow();
        int   max_cnt = 0;
        logic seen    = 1'b0;
        int   fell    = 0;
        data_v = 1'b1;
        for (int n = 0; n < 500; n++) begin
            data_i = 8'($urandom);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL ovf_cycle: edge %0d got %h want %h", m_cyc, obs, exp_vec());
            end
            if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
            if (seen && !ovf) fell++;
            if (ovf) seen = 1'b1;
        end
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got %b want 1", ovf);
        end
        checks++;
        if (fell !== 0) begin
            failures++;
            $display("FAIL ovf_sticky: cleared on %0d cycles want 0", fell);
        end
        checks++;
        if (max_cnt !== 16) begin
            failures++;
            $display("FAIL ovf_maxcnt: got %0d want 16", max_cnt);
        end
    endtask

    // Reset during data bit 3 of a frame, then silence until a fresh capture.
    task automatic test_rst_mid();
        int   phase = 0;
        int   p;
        int   busy_hi = 0;
        int   base;
        int   fe = -1;
        p = m_fs;
        for (int n = 0; n < 400 && phase < 2; n++) begin
            data_i = 8'($urandom);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL rstmid_cycle: edge %0d got %h want %h", m_cyc, obs, exp_vec());
            end
            case (phase)
                0: if (m_fs != p && m_q.size() != 0) phase = 1;
                1: if (m_cyc == m_fs + 16) begin rst = 1'b1; phase = 2; end
                default: ;
            endcase
        end
        tick();
        checks++;
        if ({tx, busy, fifo_cnt, tx0, busy0, fifo_cnt0} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0} || phase !== 2) begin
            failures++;
            $display("FAIL rstmid_abort: got tx/busy/cnt=%b/%b/%0d phase %0d want 1/0/0 phase 2", tx, busy, fifo_cnt, phase);
        end
        rst    = 1'b0;
        data_v = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL rstmid_quiet: edge %0d got %h want %h", m_cyc, obs, exp_vec());
            end
            if (busy || !tx) busy_hi++;
        end
        checks++;
        if (busy_hi !== 0) begin
            failures++;
            $display("FAIL rstmid_noframe: line active on %0d cycles want 0", busy_hi);
        end
        data_v = 1'b1;
        base   = m_cyc;
        for (int i = 1; i <= 30; i++) begin
            data_i = 8'($urandom);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL rstmid_fresh: edge %0d got %h want %h", m_cyc, obs, exp_vec());
            end
            if (!tx && fe < 0) fe = m_cyc - base;
        end
        checks++;
        if (fe !== 17) begin
            failures++;
            $display("FAIL rstmid_fall: tx fell %0d edges after data_v want 17", fe);
        end
    endtask

    initial begin
        rst    = 1'b1;
        data_v = 1'b0;
        data_i = 8'h00;
        test_reset();
        test_single_frame(8'h05, 8'h85, 8'h05, "frame05");
        test_single_frame(8'hF0, 8'h70, 8'hF0, "offsetF0");
        test_vpulse();
        test_full_pop();
        test_overflow();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
